gpr_wb_arbiter: RTL

Writer-side front end for the 32x64 general register file write port (waddr/wen/wdata). It merges writeback results from the execute unit (EXU) and the load/store unit (LSU) onto the single GRF write port. EXU results are buffered in a small FIFO whenever the LSU wins arbitration. A per-register busy scoreboard is kept for the issue stage: it is set at issue and cleared when the result is written.

---
 rtl/gpr_wb_if.sv | 26 ++
 rtl/gpr_wb_arbiter.sv | 71 +++++++
 2 files changed

// File: rtl/gpr_wb_if.sv
// gpr_wb_if: writeback sources, issue scoreboard feed and GRF write port bundle
interface gpr_wb_if #(
  parameter int XLEN = 64
);
  logic            exu_valid;
  logic            exu_ready;
  logic [4:0]      exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [31:0]     busy;
  logic [4:0]      waddr;
  logic            wen;
  logic [XLEN-1:0] wdata;
  modport master (
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data, issue_valid, issue_rd,
    input  exu_ready, busy, waddr, wen, wdata
  );
  modport slave (
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data, issue_valid, issue_rd,
    output exu_ready, busy, waddr, wen, wdata
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: merges EXU/LSU writeback onto the GRF write port, buffering EXU results and tracking busy registers
module gpr_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input logic     clock,
  input logic     reset,
  gpr_wb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic            empty, sel_fifo, sel_exu, sel, push, pop;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     set_mask, clr_mask;
  assign bus.exu_ready = count < (AW+1)'(DEPTH);
  // priority select: LSU, then oldest buffered EXU result, then EXU bypass; EXU parks in the FIFO when not taken
  always_comb begin
    empty    = count == '0;
    sel_fifo = !bus.lsu_valid && !empty;
    sel_exu  = !bus.lsu_valid && empty && bus.exu_valid && bus.exu_ready;
    sel      = bus.lsu_valid || sel_fifo || sel_exu;
    push     = bus.exu_valid && bus.exu_ready && !sel_exu;
    pop      = sel_fifo;
    sel_rd   = bus.lsu_valid ? bus.lsu_rd : sel_fifo ? fifo_rd[rd_ptr] : bus.exu_rd;
    sel_data = bus.lsu_valid ? bus.lsu_data : sel_fifo ? fifo_data[rd_ptr] : bus.exu_data;
    set_mask = (bus.issue_valid && bus.issue_rd != '0) ? 32'b1 << bus.issue_rd : '0;
    clr_mask = bus.wen ? 32'b1 << bus.waddr : '0;
  end
  // FIFO storage; contents are only meaningful below count, so no reset is needed
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.exu_rd;
      fifo_data[wr_ptr] <= bus.exu_data;
    end
  end
  // FIFO pointers wrap naturally at DEPTH; simultaneous push and pop leave count unchanged
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // registered GRF write port; x0 results are consumed without writing, address/data hold when idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.wen   <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
    end else begin
      bus.wen <= sel && sel_rd != '0;
      if (sel) begin
        bus.waddr <= sel_rd;
        bus.wdata <= sel_data;
      end
    end
  end
  // busy scoreboard: a fresh issue outranks the retiring write to the same register; x0 never busy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bus.busy <= '0;
    else bus.busy <= ((bus.busy & ~clr_mask) | set_mask) & ~32'b1;
  end
endmodule
